// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment display constants
package seg7_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    // Segment vectors are {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [3:0] CODE_DASH  = 4'hB;
    localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational display code to active-low segment decoder
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'h0:       seg = 7'b1000000;
            4'h1:       seg = 7'b1111001;
            4'h2:       seg = 7'b0100100;
            4'h3:       seg = 7'b0110000;
            4'h4:       seg = 7'b0011001;
            4'h5:       seg = 7'b0010010;
            4'h6:       seg = 7'b0000010;
            4'h7:       seg = 7'b1111000;
            4'h8:       seg = 7'b0000000;
            4'h9:       seg = 7'b0010000;
            4'hA:       seg = 7'b0001000;
            CODE_DASH:  seg = SEG_DASH;
            4'hC:       seg = 7'b1000110;
            4'hD:       seg = 7'b0100001;
            4'hE:       seg = 7'b0000110;
            CODE_BLANK: seg = SEG_BLANK;
            default:    seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit multiplexed 7-segment scan driver with per-frame snapshot
// Optional blink support: define SEG7_SCAN_DRIVER_BLINK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] disp_word,
    input  logic        disp_valid,
    input  logic [7:0]  blank_mask,
`ifdef SEG7_SCAN_DRIVER_BLINK_EN
    input  logic [7:0]  blink_mask,
`endif
    output logic        frame_strobe,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int SLOT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST      = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_BLANK_END = SLOT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0] slot_cnt;
    logic [IDX_W-1:0]  digit_idx;
    logic [31:0]       snapshot;
    logic              slot_last;
    logic              frame_end;
    logic              blink_off;
    logic              digit_blank;
    logic [3:0]        cur_code;
    logic [6:0]        cur_seg;

    assign slot_last   = (slot_cnt == SLOT_LAST);
    assign frame_end   = slot_last && (digit_idx == IDX_LAST);
    assign cur_code    = 4'(snapshot >> {digit_idx, 2'b00});
    assign digit_blank = blank_mask[digit_idx] || blink_off;
    assign dp          = 1'b1;

    seg7_decode u_decode (
        .code (cur_code),
        .seg  (cur_seg)
    );

`ifdef SEG7_SCAN_DRIVER_BLINK_EN
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_off = !blink_on && blink_mask[digit_idx];
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_CYCLES > 0);
    assign blink_off        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_last) begin
            slot_cnt  <= '0;
            digit_idx <= digit_idx + 1'b1;
        end else begin
            slot_cnt  <= slot_cnt + 1'b1;
        end
    end

    // The word is only ever latched at the frame boundary so a frame never tears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot     <= 32'hFFFF_FFFF;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= frame_end && disp_valid;
            if (frame_end && disp_valid) begin
                snapshot <= disp_word;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
        end else if (slot_cnt < SLOT_BLANK_END) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= digit_blank ? 8'hFF : ~(8'h01 << digit_idx);
            seg <= cur_seg;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int D     = 8;
    localparam int BK    = 2;
    localparam int BL    = 64;
    localparam int FRAME = 8 * D;
`ifdef SEG7_SCAN_DRIVER_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] disp_word = 32'h0;
    logic        disp_valid = 1'b0;
    logic [7:0]  blank_mask = 8'h00;
    logic [7:0]  blink_mask = 8'h00;
    logic        frame_strobe;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGIT_CYCLES (D),
        .BLANK_CYCLES (BK),
        .BLINK_CYCLES (BL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .disp_word    (disp_word),
        .disp_valid   (disp_valid),
        .blank_mask   (blank_mask),
`ifdef SEG7_SCAN_DRIVER_BLINK_EN
        .blink_mask   (blink_mask),
`endif
        .frame_strobe (frame_strobe),
        .an           (an),
        .seg          (seg),
        .dp           (dp)
    );

    // Reference glyphs written as lit segments (common-cathode style), then inverted
    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        logic [6:0] lit;
        case (c)
            4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h40;
            4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  default: lit = 7'h00;
        endcase
        return ~lit;
    endfunction

    // Model: n = clock edges since reset release; slot/digit/frame follow from arithmetic on n
    int          n = 0;
    logic [31:0] m_snap = 32'hFFFF_FFFF;
    logic [7:0]  m_an = 8'hFF;
    logic [6:0]  m_seg = 7'h7F;
    logic        m_strobe = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n = 0; m_snap = 32'hFFFF_FFFF; m_an = 8'hFF; m_seg = 7'h7F; m_strobe = 1'b0;
        end else begin
            int   slot, dig;
            logic off;
            slot = n % D;
            dig  = (n / D) % 8;
            off  = blank_mask[dig] || (BLINK_EN && ((n / BL) % 2 == 1) && blink_mask[dig]);
            if (slot < BK) begin
                m_an = 8'hFF; m_seg = 7'h7F;
            end else begin
                m_an  = off ? 8'hFF : (8'hFF ^ (8'h01 << dig));
                m_seg = ref_seg(m_snap[dig*4 +: 4]);
            end
            m_strobe = ((n % FRAME) == FRAME - 1) && disp_valid;
            if (m_strobe) m_snap = disp_word;
            n++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (!reset) begin
            check("an_model", an, m_an);
            check("seg_model", seg, m_seg);
            check("strobe_model", frame_strobe, m_strobe);
            check("dp_off", dp, 1'b1);
            check("an_onehot", ($countones(~an) <= 1), 1'b1);
        end
    endtask

    task automatic scramble();
        disp_word  = $urandom;
        disp_valid = 1'($urandom);
    endtask

    task automatic wait_boundary();
        for (int i = 0; i < FRAME && (n % FRAME) != FRAME - 1; i++) begin
            scramble();
            step();
        end
    endtask

    typedef struct {
        logic [31:0] word;
        logic        valid;
        logic [7:0]  bmask;
        logic        exp_strobe;
        logic [31:0] exp_word;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'h12B34B56, 1'b1, 8'h00, 1'b1, 32'h12B34B56};
        tbl[1] = '{32'h00000000, 1'b0, 8'h00, 1'b0, 32'h12B34B56};
        tbl[2] = '{32'h00000000, 1'b1, 8'h00, 1'b1, 32'h00000000};
        tbl[3] = '{32'hA5C9DE07, 1'b1, 8'h81, 1'b1, 32'hA5C9DE07};
        tbl[4] = '{32'hFFFFFFFF, 1'b0, 8'h81, 1'b0, 32'hA5C9DE07};
        tbl[5] = '{32'h87654321, 1'b1, 8'h7E, 1'b1, 32'h87654321};

        #1 reset = 1'b1;
        repeat (3) step();
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_strobe", frame_strobe, 1'b0);
        check("rst_dp", dp, 1'b1);
        reset = 1'b0;

        // Reset asserted while a digit is lit must clear outputs without a clock edge
        disp_valid = 1'b1;
        disp_word  = 32'h88888888;
        repeat (5) step();
        check("pre_rst_an", an, 8'hFE);
        #2 reset = 1'b1;
        #1;
        check("async_rst_an", an, 8'hFF);
        check("async_rst_seg", seg, 7'h7F);
        check("async_rst_strobe", frame_strobe, 1'b0);
        repeat (2) step();
        reset = 1'b0;

        // First frame after release shows the all-blank snapshot
        for (int i = 0; i < FRAME - 1; i++) begin
            disp_word  = $urandom;
            disp_valid = 1'b1;
            step();
            check("first_frame_seg", seg, 7'h7F);
            check("first_frame_strobe", frame_strobe, 1'b0);
        end

        for (int e = 0; e < 6; e++) begin
            wait_boundary();
            disp_word  = tbl[e].word;
            disp_valid = tbl[e].valid;
            blank_mask = tbl[e].bmask;
            step();
            check("boundary_strobe", frame_strobe, tbl[e].exp_strobe);
            for (int d = 0; d < 8; d++) begin
                for (int i = 0; i < FRAME && (n % FRAME) != d * D + BK + 1; i++) begin
                    scramble();
                    step();
                end
                check("digit_seg", seg, ref_seg(tbl[e].exp_word[d*4 +: 4]));
                check("digit_an", an, tbl[e].bmask[d] ? 8'hFF : (8'hFF ^ (8'h01 << d)));
            end
        end

        // Randomised traffic against the model, including live mask changes
        for (int i = 0; i < 600; i++) begin
            disp_word  = $urandom;
            disp_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) blank_mask = 8'($urandom);
            if ($urandom_range(0, 31) == 0) blink_mask = 8'($urandom);
            step();
        end

        // Blink pattern on digits 0-1 across several blink half-periods
        blank_mask = 8'h00;
        blink_mask = 8'h03;
        repeat (4 * BL) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
